// File: rtl/dma_pkg.sv
// Shared DMA definitions used by both the DMA engine and its memory responder.
package dma_pkg;

    localparam int unsigned DMA_ADDR_W = 32;
    localparam int unsigned DMA_DATA_W = 32;

    // Data returned for reads that miss the array or are misaligned
    localparam logic [DMA_DATA_W-1:0] DMA_RD_ERR_DATA = 32'h0000_0000;

endpackage

// File: rtl/dma_mem_rd_pipe.sv
// Read-return delay line of {valid, data}. Provides LATENCY-1 register stages;
// the responder's output register supplies the final stage, so the total
// delay from strobe edge to mem_read update is LATENCY-1 edges after sampling.
module dma_mem_rd_pipe
    import dma_pkg::*;
#(
    parameter int unsigned LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [DMA_DATA_W-1:0] in_data,
    output logic                  out_valid,
    output logic [DMA_DATA_W-1:0] out_data
);

    localparam int unsigned STAGES = LATENCY - 1;

    if (STAGES == 0) begin : g_bypass
        assign out_valid = in_valid;
        assign out_data  = in_data;
    end else begin : g_stages
        logic [STAGES-1:0]     valid_q;
        logic [DMA_DATA_W-1:0] data_q [STAGES];

        // Valid bits shift every cycle and are flushed by reset
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                valid_q <= '0;
            end else begin
                valid_q[0] <= in_valid;
                for (int i = 1; i < STAGES; i++) begin
                    valid_q[i] <= valid_q[i-1];
                end
            end
        end

        // Data shifts alongside valid; no reset needed since valid qualifies it
        always_ff @(posedge clk) begin
            data_q[0] <= in_data;
            for (int i = 1; i < STAGES; i++) begin
                data_q[i] <= data_q[i-1];
            end
        end

        assign out_valid = valid_q[STAGES-1];
        assign out_data  = data_q[STAGES-1];
    end

endmodule

// File: rtl/dma_mem_responder.sv
// Memory-side responder for the DMA memory port: word array, fixed-latency
// read return, access counters and a sticky protocol-error flag.
module dma_mem_responder
    import dma_pkg::*;
#(
    parameter int unsigned          DEPTH        = 256,
    parameter int unsigned          READ_LATENCY = 1,
    parameter logic [DMA_ADDR_W-1:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DMA_ADDR_W-1:0] mem_addr,
    input  logic [DMA_DATA_W-1:0] mem_write,
    input  logic                  mem_r_en,
    input  logic                  mem_w_en,
    output logic [DMA_DATA_W-1:0] mem_read,
    output logic                  rd_valid,
    output logic                  err,
    input  logic                  err_clr,
    output logic [31:0]           rd_count,
    output logic [31:0]           wr_count
);

    localparam int unsigned IDX_W = $clog2(DEPTH);

    logic [DMA_ADDR_W-1:0] offset;
    logic [IDX_W-1:0]      idx;
    logic                  in_range;
    logic                  wr_fire;
    logic                  err_set;
    logic [DMA_DATA_W-1:0] fetch_data;
    logic                  pipe_valid;
    logic [DMA_DATA_W-1:0] pipe_data;

    logic [DMA_DATA_W-1:0] mem_array [DEPTH];

    // Address decode and error detection
    always_comb begin
        offset   = mem_addr - BASE_ADDR;
        idx      = offset[IDX_W+1:2];
        in_range = (mem_addr[1:0] == 2'b00) && ((offset >> 2) < DEPTH);
        wr_fire  = mem_w_en && in_range && !rst;
        err_set  = (mem_r_en && mem_w_en) || ((mem_r_en || mem_w_en) && !in_range);
        // Combinational fetch gives read-before-write on a simultaneous access
        fetch_data = in_range ? mem_array[idx] : DMA_RD_ERR_DATA;
    end

    // Array write; contents survive reset
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem_array[idx] <= mem_write;
        end
    end

    dma_mem_rd_pipe #(
        .LATENCY (READ_LATENCY)
    ) u_rd_pipe (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (mem_r_en),
        .in_data   (fetch_data),
        .out_valid (pipe_valid),
        .out_data  (pipe_data)
    );

    // Output register, counters and sticky error (set beats clear)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_read <= '0;
            rd_valid <= 1'b0;
            err      <= 1'b0;
            rd_count <= '0;
            wr_count <= '0;
        end else begin
            rd_valid <= pipe_valid;
            if (pipe_valid) begin
                mem_read <= pipe_data;
                rd_count <= rd_count + 32'd1;
            end
            if (mem_w_en && in_range) begin
                wr_count <= wr_count + 32'd1;
            end
            if (err_set) begin
                err <= 1'b1;
            end else if (err_clr) begin
                err <= 1'b0;
            end
        end
    end

endmodule
